// File: rtl/traffic_light_ctrl.sv
// Multi-approach traffic light controller: rotating green phases with demand skipping,
// min/max green timing, yellow and all-red clearance, and a flashing-yellow night mode.
module traffic_light_ctrl #(
  parameter int NUM_DIR   = 4,
  parameter int PH_W      = 2,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [NUM_DIR-1:0]     T,
  input  logic                   flash_en,
  output logic [2*NUM_DIR-1:0]   L,
  output logic [3:0]             S,
  output logic [PH_W-1:0]        phase,
  output logic [CNT_W-1:0]       timer
);

  localparam logic [3:0] ST_GREEN  = 4'b0001;
  localparam logic [3:0] ST_YELLOW = 4'b0010;
  localparam logic [3:0] ST_ALLRED = 4'b0100;
  localparam logic [3:0] ST_FLASH  = 4'b1000;

  localparam logic [CNT_W:0] LEN_GMIN = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0] LEN_GMAX = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0] LEN_Y    = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0] LEN_AR   = (CNT_W+1)'(ALLRED_T);
  localparam logic [CNT_W-1:0] REST_MAX = CNT_W'(GREEN_MAX - 1);

  logic                 blink;
  logic [CNT_W:0]       timer_inc;
  logic                 other;
  logic [PH_W-1:0]      next_phase;
  logic [NUM_DIR-1:0]   phase_mask;
  logic [2*NUM_DIR-1:0] rot_wide;
  logic [NUM_DIR-1:0]   rot;
  int                   offset;
  int                   sum;

  // Widened increment so the done comparison can never wrap.
  assign timer_inc  = {1'b0, timer} + {{CNT_W{1'b0}}, 1'b1};
  assign phase_mask = {{(NUM_DIR-1){1'b0}}, 1'b1} << phase;
  assign other      = |(T & ~phase_mask);

  // Rotate demand so rot[k] is approach phase+k; smallest demanded k >= 1 wins.
  always_comb begin
    rot_wide = {T, T} >> phase;
    rot      = rot_wide[NUM_DIR-1:0];
    offset   = 1;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      if (rot[k]) offset = k;
      else        offset = offset;
    end
    sum = int'(phase) + offset;
    if (sum >= NUM_DIR) sum = sum - NUM_DIR;
    else                sum = sum;
    next_phase = PH_W'(sum);
  end

  // Interval sequencing; every transition is qualified by tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      S     <= ST_GREEN;
      phase <= '0;
      timer <= '0;
      blink <= 1'b0;
    end else if (tick) begin
      case (S)
        ST_GREEN: begin
          if (flash_en) begin
            S     <= ST_YELLOW;
            timer <= '0;
          end else if (!other) begin
            timer <= (timer_inc >= LEN_GMAX) ? REST_MAX : timer_inc[CNT_W-1:0];
          end else if (timer_inc >= LEN_GMAX) begin
            S     <= ST_YELLOW;
            timer <= '0;
          end else if ((timer_inc >= LEN_GMIN) && !T[phase]) begin
            S     <= ST_YELLOW;
            timer <= '0;
          end else begin
            timer <= timer_inc[CNT_W-1:0];
          end
        end
        ST_YELLOW: begin
          if (timer_inc >= LEN_Y) begin
            S     <= ST_ALLRED;
            timer <= '0;
          end else begin
            timer <= timer_inc[CNT_W-1:0];
          end
        end
        ST_ALLRED: begin
          if (timer_inc >= LEN_AR) begin
            timer <= '0;
            if (flash_en) begin
              S     <= ST_FLASH;
              blink <= 1'b1;
            end else begin
              S     <= ST_GREEN;
              phase <= next_phase;
            end
          end else begin
            timer <= timer_inc[CNT_W-1:0];
          end
        end
        ST_FLASH: begin
          blink <= ~blink;
          timer <= '0;
          if (!flash_en) S <= ST_ALLRED;
        end
        default: begin
          S     <= ST_GREEN;
          phase <= '0;
          timer <= '0;
          blink <= 1'b0;
        end
      endcase
    end
  end

  // Lamp decode from the registered state.
  always_comb begin
    L = '1;
    case (S)
      ST_GREEN: begin
        for (int i = 0; i < NUM_DIR; i++)
          L[2*i +: 2] = (PH_W'(i) == phase) ? 2'b00 : 2'b10;
      end
      ST_YELLOW: begin
        for (int i = 0; i < NUM_DIR; i++)
          L[2*i +: 2] = (PH_W'(i) == phase) ? 2'b01 : 2'b10;
      end
      ST_ALLRED: begin
        for (int i = 0; i < NUM_DIR; i++) L[2*i +: 2] = 2'b10;
      end
      ST_FLASH: begin
        for (int i = 0; i < NUM_DIR; i++) L[2*i +: 2] = blink ? 2'b01 : 2'b11;
      end
      default: begin
        for (int i = 0; i < NUM_DIR; i++) L[2*i +: 2] = 2'b10;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed-vector bench for traffic_light_ctrl: the driver queues the hand-computed
// post-edge state, and an independent monitor pops and compares it on the falling edge.
module tb_traffic_light_ctrl;

  localparam logic [3:0] SG = 4'b0001;
  localparam logic [3:0] SY = 4'b0010;
  localparam logic [3:0] SA = 4'b0100;
  localparam logic [3:0] SF = 4'b1000;

  localparam logic [7:0] LG0 = 8'b10101000;
  localparam logic [7:0] LG1 = 8'b10100010;
  localparam logic [7:0] LG2 = 8'b10001010;
  localparam logic [7:0] LG3 = 8'b00101010;
  localparam logic [7:0] LY0 = 8'b10101001;
  localparam logic [7:0] LY1 = 8'b10100110;
  localparam logic [7:0] LY2 = 8'b10011010;
  localparam logic [7:0] LY3 = 8'b01101010;
  localparam logic [7:0] LAR = 8'b10101010;
  localparam logic [7:0] LF1 = 8'b01010101;
  localparam logic [7:0] LF0 = 8'b11111111;

  typedef struct {
    int         id;
    logic [3:0] s;
    logic [1:0] ph;
    logic [7:0] tm;
    logic [7:0] l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] T = 4'b0000;
  logic       flash_en = 1'b0;
  logic [7:0] L;
  logic [3:0] S;
  logic [1:0] phase;
  logic [7:0] timer;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   vec_id = 0;

  traffic_light_ctrl #(
    .NUM_DIR(4), .PH_W(2), .CNT_W(8),
    .GREEN_MIN(2), .GREEN_MAX(4), .YELLOW_T(1), .ALLRED_T(1)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .T(T), .flash_en(flash_en),
    .L(L), .S(S), .phase(phase), .timer(timer)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic tk, input logic fl, input logic [3:0] t,
                      input logic [3:0] s, input logic [1:0] ph, input logic [7:0] tm,
                      input logic [7:0] l);
    exp_t e;
    @(negedge clk);
    rst = r; tick = tk; flash_en = fl; T = t;
    @(posedge clk);
    e.id = vec_id; e.s = s; e.ph = ph; e.tm = tm; e.l = l;
    q.push_back(e);
    vec_id++;
  endtask

  // Monitor: compare queued expectations and the single-non-red property.
  initial begin
    exp_t e;
    int   nonred;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (S === e.s && phase === e.ph && timer === e.tm && L === e.l) passed++;
        else $display("FAIL vec%0d: got S=%b phase=%0d timer=%0d L=%b, want S=%b phase=%0d timer=%0d L=%b",
                      e.id, S, phase, timer, L, e.s, e.ph, e.tm, e.l);
        nonred = 0;
        for (int i = 0; i < 4; i++) if (L[2*i +: 2] != 2'b10) nonred++;
        checks++;
        if (S == SF || nonred <= 1) passed++;
        else $display("FAIL nonred vec%0d: got %0d non-red approaches, want at most 1", e.id, nonred);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset and rest-in-green with no demand
    step(1, 1, 0, 4'b0000, SG, 2'd0, 8'd0, LG0);
    for (int i = 0; i < 6; i++)
      step(0, 1, 0, 4'b0000, SG, 2'd0, (i < 3) ? 8'(i + 1) : 8'd3, LG0);
    // gap-out and max-out on the same tick: one yellow
    step(0, 1, 0, 4'b0010, SY, 2'd0, 8'd0, LY0);
    step(0, 1, 0, 4'b0010, SA, 2'd0, 8'd0, LAR);
    step(0, 1, 0, 4'b0010, SG, 2'd1, 8'd0, LG1);

    // 2: max-out rotation 0 -> 2 -> 0
    step(1, 1, 0, 4'b0101, SG, 2'd0, 8'd0, LG0);
    step(0, 1, 0, 4'b0101, SG, 2'd0, 8'd1, LG0);
    step(0, 1, 0, 4'b0101, SG, 2'd0, 8'd2, LG0);
    step(0, 1, 0, 4'b0101, SG, 2'd0, 8'd3, LG0);
    step(0, 1, 0, 4'b0101, SY, 2'd0, 8'd0, LY0);
    step(0, 1, 0, 4'b0101, SA, 2'd0, 8'd0, LAR);
    step(0, 1, 0, 4'b0101, SG, 2'd2, 8'd0, LG2);
    step(0, 1, 0, 4'b0101, SG, 2'd2, 8'd1, LG2);
    step(0, 1, 0, 4'b0101, SG, 2'd2, 8'd2, LG2);
    step(0, 1, 0, 4'b0101, SG, 2'd2, 8'd3, LG2);
    step(0, 1, 0, 4'b0101, SY, 2'd2, 8'd0, LY2);
    step(0, 1, 0, 4'b0101, SA, 2'd2, 8'd0, LAR);
    step(0, 1, 0, 4'b0101, SG, 2'd0, 8'd0, LG0);

    // 3: gap-out to approach 1, then rest on it
    step(1, 1, 0, 4'b0010, SG, 2'd0, 8'd0, LG0);
    step(0, 1, 0, 4'b0010, SG, 2'd0, 8'd1, LG0);
    step(0, 1, 0, 4'b0010, SY, 2'd0, 8'd0, LY0);
    step(0, 1, 0, 4'b0010, SA, 2'd0, 8'd0, LAR);
    step(0, 1, 0, 4'b0010, SG, 2'd1, 8'd0, LG1);
    step(0, 1, 0, 4'b0010, SG, 2'd1, 8'd1, LG1);
    step(0, 1, 0, 4'b0010, SG, 2'd1, 8'd2, LG1);
    step(0, 1, 0, 4'b0010, SG, 2'd1, 8'd3, LG1);
    step(0, 1, 0, 4'b0010, SG, 2'd1, 8'd3, LG1);

    // 4: demand on 3 then wrap-around 3 -> 0
    step(0, 1, 0, 4'b1000, SY, 2'd1, 8'd0, LY1);
    step(0, 1, 0, 4'b1000, SA, 2'd1, 8'd0, LAR);
    step(0, 1, 0, 4'b1000, SG, 2'd3, 8'd0, LG3);
    step(0, 1, 0, 4'b0001, SG, 2'd3, 8'd1, LG3);
    step(0, 1, 0, 4'b0001, SY, 2'd3, 8'd0, LY3);
    step(0, 1, 0, 4'b0001, SA, 2'd3, 8'd0, LAR);
    step(0, 1, 0, 4'b0001, SG, 2'd0, 8'd0, LG0);

    // 5: night mode entry, blinking, exit to next demanded phase
    step(0, 1, 1, 4'b0001, SY, 2'd0, 8'd0, LY0);
    step(0, 1, 1, 4'b0001, SA, 2'd0, 8'd0, LAR);
    step(0, 1, 1, 4'b0001, SF, 2'd0, 8'd0, LF1);
    step(0, 1, 1, 4'b0001, SF, 2'd0, 8'd0, LF0);
    step(0, 1, 1, 4'b0001, SF, 2'd0, 8'd0, LF1);
    step(0, 1, 1, 4'b0001, SF, 2'd0, 8'd0, LF0);
    step(0, 1, 0, 4'b0100, SA, 2'd0, 8'd0, LAR);
    step(0, 1, 0, 4'b0100, SG, 2'd2, 8'd0, LG2);

    // 6: tick=0 freeze, reset in YELLOW and in FLASH
    step(0, 1, 0, 4'b0101, SG, 2'd2, 8'd1, LG2);
    step(0, 0, 1, 4'b1111, SG, 2'd2, 8'd1, LG2);
    step(0, 0, 0, 4'b0000, SG, 2'd2, 8'd1, LG2);
    step(0, 0, 1, 4'b0001, SG, 2'd2, 8'd1, LG2);
    step(0, 0, 0, 4'b1010, SG, 2'd2, 8'd1, LG2);
    step(0, 0, 1, 4'b0000, SG, 2'd2, 8'd1, LG2);
    step(0, 1, 0, 4'b0101, SG, 2'd2, 8'd2, LG2);
    step(0, 1, 0, 4'b0101, SG, 2'd2, 8'd3, LG2);
    step(0, 1, 0, 4'b0101, SY, 2'd2, 8'd0, LY2);
    step(1, 1, 0, 4'b0101, SG, 2'd0, 8'd0, LG0);
    step(0, 1, 1, 4'b0000, SY, 2'd0, 8'd0, LY0);
    step(0, 1, 1, 4'b0000, SA, 2'd0, 8'd0, LAR);
    step(0, 1, 1, 4'b0000, SF, 2'd0, 8'd0, LF1);
    step(1, 0, 1, 4'b0000, SG, 2'd0, 8'd0, LG0);
    step(0, 1, 0, 4'b0000, SG, 2'd0, 8'd1, LG0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
